// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types, reset values and sizing helper for the sync FIFO
package fifo_pkg;
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

  localparam fifo_status_t STATUS_RST = '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1};

  // One extra wrap bit lets full and empty be told apart when the addresses match
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port RAM, synchronous write and registered read on one clock
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end
  // Same-address read and write returns the old word, so a pop at full gets the oldest entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO with registered status flags and sticky error flags
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int AFULL_LVL  = 12,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  fifo_status_t  st_q, st_d;
  logic          rd_valid_q, overflow_q, underflow_q;
  logic          do_push, do_pop;

  // Flags are computed from next-state pointers so they change with the pointers
  always_comb begin
    do_pop            = pop && !st_q.empty;
    do_push           = push && (!st_q.full || pop);
    wr_ptr_d          = wr_ptr_q + PW'(do_push);
    rd_ptr_d          = rd_ptr_q + PW'(do_pop);
    count_d           = wr_ptr_d - rd_ptr_d;
    st_d.empty        = wr_ptr_d == rd_ptr_d;
    st_d.full         = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
    st_d.almost_full  = count_d >= PW'(AFULL_LVL);
    st_d.almost_empty = count_d <= PW'(AEMPTY_LVL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      st_q        <= STATUS_RST;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      st_q        <= st_d;
      rd_valid_q  <= do_pop;
      overflow_q  <= overflow_q | (push && !do_push);
      underflow_q <= underflow_q | (pop && !do_pop);
    end
  end

  fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (do_push),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wr_data),
    .re_i    (do_pop),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rd_data)
  );

  assign rd_valid     = rd_valid_q;
  assign full         = st_q.full;
  assign empty        = st_q.empty;
  assign almost_full  = st_q.almost_full;
  assign almost_empty = st_q.almost_empty;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
endmodule
